// File: rtl/ifmap_row_loader.sv
// ---------------------------------------------------------------------------
// ifmap_row_loader
// Upstream feeder for the PE datapath IFMap FIFO. Takes a valid/ready pixel
// stream, tags each pixel with start-of-row / end-of-row flags and writes the
// tagged word into the IFMap FIFO with zero-cycle latency, never while the
// FIFO is full. Counts columns/rows of a programmed frame and pulses done
// once the last pixel has been written.
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   start      one-cycle frame start, honoured only in IDLE
//   row_len    pixels per row (latched at start)
//   num_rows   rows per frame (latched at start)
//   in_data    pixel from activation memory
//   in_valid   in_data is valid
//   in_ready   loader accepts in_data this cycle
//   fifo_full  IFMap FIFO full flag
//   fifo_wen   IFMap FIFO write enable
//   fifo_din   tagged word {start_of_row, end_of_row, pixel}
//   busy       high while loading a frame
//   done       one-cycle pulse when the frame completes
//   pix_count  pixels written in the current or last frame
// ---------------------------------------------------------------------------
module ifmap_row_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int IFMAP_WIDTH = 18,
    parameter int LEN_SIZE    = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [LEN_SIZE-1:0]     row_len,
    input  logic [LEN_SIZE-1:0]     num_rows,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wen,
    output logic [IFMAP_WIDTH-1:0]  fifo_din,
    output logic                    busy,
    output logic                    done,
    output logic [2*LEN_SIZE-1:0]   pix_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_SIZE-1:0]    len_q,   len_d;
    logic [LEN_SIZE-1:0]    rows_q,  rows_d;
    logic [LEN_SIZE-1:0]    col_q,   col_d;
    logic [LEN_SIZE-1:0]    row_q,   row_d;
    logic [2*LEN_SIZE-1:0]  pix_q,   pix_d;

    // Last-column / last-row detection. Lengths are never 0 in LOAD, so the
    // minus-one values cannot underflow there; 255 stays legal at 8 bits.
    logic [LEN_SIZE-1:0]    len_m1_s;
    logic [LEN_SIZE-1:0]    rows_m1_s;
    logic                   last_col_s;
    logic                   last_row_s;
    logic                   xfer_s;

    assign len_m1_s   = len_q  - LEN_SIZE'(1);
    assign rows_m1_s  = rows_q - LEN_SIZE'(1);
    assign last_col_s = (col_q == len_m1_s);
    assign last_row_s = (row_q == rows_m1_s);

    // Next-state, counter update and combinational output decode.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rows_d    = rows_q;
        col_d     = col_q;
        row_d     = row_q;
        pix_d     = pix_q;
        in_ready  = 1'b0;
        fifo_wen  = 1'b0;
        fifo_din  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        xfer_s    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d  = row_len;
                    rows_d = num_rows;
                    col_d  = '0;
                    row_d  = '0;
                    pix_d  = '0;
                    // An empty frame completes immediately with no writes.
                    if ((row_len == '0) || (num_rows == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            LOAD: begin
                busy     = 1'b1;
                in_ready = !fifo_full;
                xfer_s   = in_valid && !fifo_full;
                if (xfer_s) begin
                    fifo_wen = 1'b1;
                    fifo_din = {(col_q == '0), last_col_s, in_data};
                    pix_d    = pix_q + {{(2*LEN_SIZE-1){1'b0}}, 1'b1};
                    if (last_col_s) begin
                        col_d = '0;
                        row_d = row_q + LEN_SIZE'(1);
                        if (last_row_s) begin
                            state_d = DONE;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        col_d = col_q + LEN_SIZE'(1);
                    end
                end else begin
                    // Stalled or no data: counters and pending pixel hold.
                    state_d = LOAD;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            len_q   <= '0;
            rows_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rows_q  <= rows_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pix_q   <= pix_d;
        end
    end

    assign pix_count = pix_q;

endmodule

// File: tb/tb_ifmap_row_loader.sv
// ---------------------------------------------------------------------------
// tb_ifmap_row_loader
// Directed, table-driven bench. Each vector is one clock cycle: inputs are
// driven on the falling edge, outputs are sampled 1ns later (before the next
// rising edge), so combinational outputs reflect the current inputs and the
// state registered at the previous rising edge.
// ---------------------------------------------------------------------------
module tb_ifmap_row_loader;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [7:0]  row_len;
    logic [7:0]  num_rows;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        fifo_full;
    logic        fifo_wen;
    logic [17:0] fifo_din;
    logic        busy;
    logic        done;
    logic [15:0] pix_count;

    int n_vec;
    int n_err;

    typedef struct {
        logic        rstn;
        logic        start;
        logic [7:0]  rl;
        logic [7:0]  nr;
        logic [15:0] d;
        logic        v;
        logic        full;
        logic        rdy;
        logic        wen;
        logic [17:0] din;
        logic        busy;
        logic        done;
        logic [15:0] pix;
    } vec_t;

    ifmap_row_loader #(
        .DATA_WIDTH (16),
        .IFMAP_WIDTH(18),
        .LEN_SIZE   (8)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .row_len  (row_len),
        .num_rows (num_rows),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fifo_full(fifo_full),
        .fifo_wen (fifo_wen),
        .fifo_din (fifo_din),
        .busy     (busy),
        .done     (done),
        .pix_count(pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rs, input logic st, input logic [7:0] rl, input logic [7:0] nr,
        input logic [15:0] d, input logic v, input logic full,
        input logic rdy, input logic wen, input logic [17:0] din,
        input logic bsy, input logic dn, input logic [15:0] pix);
        vec_t t;
        t.rstn = rs;  t.start = st; t.rl = rl; t.nr = nr;
        t.d = d;      t.v = v;      t.full = full;
        t.rdy = rdy;  t.wen = wen;  t.din = din;
        t.busy = bsy; t.done = dn;  t.pix = pix;
        return t;
    endfunction

    // Drive one cycle of inputs and compare all outputs.
    task automatic apply(input vec_t t, input string nm);
        @(negedge clk);
        rstn      = t.rstn;
        start     = t.start;
        row_len   = t.rl;
        num_rows  = t.nr;
        in_data   = t.d;
        in_valid  = t.v;
        fifo_full = t.full;
        #1;
        n_vec++;
        if (in_ready !== t.rdy || fifo_wen !== t.wen || fifo_din !== t.din ||
            busy !== t.busy || done !== t.done || pix_count !== t.pix) begin
            n_err++;
            $display("FAIL %s: got rdy=%b wen=%b din=%h busy=%b done=%b pix=%0d, expected rdy=%b wen=%b din=%h busy=%b done=%b pix=%0d",
                     nm, in_ready, fifo_wen, fifo_din, busy, done, pix_count,
                     t.rdy, t.wen, t.din, t.busy, t.done, t.pix);
        end
    endtask

    // Shorthands: idle cycle, and a LOAD cycle with valid data and no stall.
    task automatic idle_chk(input logic dn, input logic [15:0] pix, input string nm);
        apply(mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 18'h0, 1'b0, dn, pix), nm);
    endtask

    task automatic wr_chk(input logic [15:0] d, input logic [17:0] din,
                          input logic [15:0] pix, input string nm);
        apply(mk(1'b1, 1'b0, 8'd0, 8'd0, d, 1'b1, 1'b0,
                 1'b1, 1'b1, din, 1'b1, 1'b0, pix), nm);
    endtask

    task automatic start_chk(input logic [7:0] rl, input logic [7:0] nr,
                             input logic [15:0] pix, input string nm);
        apply(mk(1'b1, 1'b1, rl, nr, 16'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, pix), nm);
    endtask

    vec_t tbl [10];

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rstn      = 1'b0;
        start     = 1'b0;
        row_len   = 8'd0;
        num_rows  = 8'd0;
        in_data   = 16'h0;
        in_valid  = 1'b0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);

        // Basic 3x2 frame, pixels 1..6.
        tbl[0] = mk(1'b0, 1'b0, 8'd0, 8'd0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 16'd0);
        tbl[1] = mk(1'b1, 1'b1, 8'd3, 8'd2, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 16'd0);
        tbl[2] = mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1, 18'h20001, 1'b1, 1'b0, 16'd0);
        tbl[3] = mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1, 18'h00002, 1'b1, 1'b0, 16'd1);
        tbl[4] = mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1, 18'h10003, 1'b1, 1'b0, 16'd2);
        tbl[5] = mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b1, 18'h20004, 1'b1, 1'b0, 16'd3);
        tbl[6] = mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b1, 18'h00005, 1'b1, 1'b0, 16'd4);
        tbl[7] = mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0006, 1'b1, 1'b0, 1'b1, 1'b1, 18'h10006, 1'b1, 1'b0, 16'd5);
        tbl[8] = mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b1, 16'd6);
        tbl[9] = mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 16'd6);
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i], $sformatf("basic[%0d]", i));
        end

        // Backpressure: 4 stalled cycles after the 2nd write.
        start_chk(8'd3, 8'd2, 16'd6, "bp_start");
        wr_chk(16'h0001, 18'h20001, 16'd0, "bp_w1");
        wr_chk(16'h0002, 18'h00002, 16'd1, "bp_w2");
        for (int i = 0; i < 4; i++) begin
            apply(mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0003, 1'b1, 1'b1,
                     1'b0, 1'b0, 18'h0, 1'b1, 1'b0, 16'd2), $sformatf("bp_stall%0d", i));
        end
        wr_chk(16'h0003, 18'h10003, 16'd2, "bp_w3");
        wr_chk(16'h0004, 18'h20004, 16'd3, "bp_w4");
        wr_chk(16'h0005, 18'h00005, 16'd4, "bp_w5");
        wr_chk(16'h0006, 18'h10006, 16'd5, "bp_w6");
        idle_chk(1'b1, 16'd6, "bp_done");
        idle_chk(1'b0, 16'd6, "bp_idle");

        // Sparse input: 4x1 frame with in_valid toggling.
        start_chk(8'd4, 8'd1, 16'd6, "sp_start");
        for (int i = 0; i < 4; i++) begin
            logic [15:0] d;
            logic [17:0] e;
            d = 16'h0011 * 16'(i + 1);
            e = {(i == 0), (i == 3), d};
            wr_chk(d, e, 16'(i), $sformatf("sp_w%0d", i));
            apply(mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0, 1'b0, 1'b0,
                     (i != 3), 1'b0, 18'h0, (i != 3), (i == 3), 16'(i + 1)),
                  $sformatf("sp_gap%0d", i));
        end
        idle_chk(1'b0, 16'd4, "sp_idle");

        // Single-pixel rows: every word carries both flags.
        start_chk(8'd1, 8'd3, 16'd4, "r1_start");
        wr_chk(16'h00AA, 18'h300AA, 16'd0, "r1_w0");
        wr_chk(16'h00BB, 18'h300BB, 16'd1, "r1_w1");
        wr_chk(16'h00CC, 18'h300CC, 16'd2, "r1_w2");
        idle_chk(1'b1, 16'd3, "r1_done");

        // Zero-length row: done with no writes, even with data offered.
        start_chk(8'd0, 8'd5, 16'd3, "z_start");
        apply(mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h1234, 1'b1, 1'b0,
                 1'b0, 1'b0, 18'h0, 1'b0, 1'b1, 16'd0), "z_done");
        idle_chk(1'b0, 16'd0, "z_idle");

        // Mid-frame reset after 2 writes, then a 2x1 restart.
        start_chk(8'd3, 8'd2, 16'd0, "mr_start");
        wr_chk(16'h0001, 18'h20001, 16'd0, "mr_w1");
        wr_chk(16'h0002, 18'h00002, 16'd1, "mr_w2");
        apply(mk(1'b0, 1'b0, 8'd0, 8'd0, 16'h0, 1'b0, 1'b0,
                 1'b1, 1'b0, 18'h0, 1'b1, 1'b0, 16'd2), "mr_rst0");
        apply(mk(1'b0, 1'b0, 8'd0, 8'd0, 16'h0003, 1'b1, 1'b0,
                 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 16'd0), "mr_rst1");
        apply(mk(1'b1, 1'b0, 8'd0, 8'd0, 16'h0003, 1'b1, 1'b0,
                 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 16'd0), "mr_after");
        start_chk(8'd2, 8'd1, 16'd0, "mr_restart");
        wr_chk(16'h000B, 18'h2000B, 16'd0, "mr_r1");
        wr_chk(16'h000C, 18'h1000C, 16'd1, "mr_r2");
        idle_chk(1'b1, 16'd2, "mr_done");

        // start pulsed mid-frame is ignored.
        start_chk(8'd3, 8'd2, 16'd2, "si_start");
        wr_chk(16'h0001, 18'h20001, 16'd0, "si_w1");
        apply(mk(1'b1, 1'b1, 8'd5, 8'd9, 16'h0002, 1'b1, 1'b0,
                 1'b1, 1'b1, 18'h00002, 1'b1, 1'b0, 16'd1), "si_w2_start");
        wr_chk(16'h0003, 18'h10003, 16'd2, "si_w3");
        wr_chk(16'h0004, 18'h20004, 16'd3, "si_w4");
        wr_chk(16'h0005, 18'h00005, 16'd4, "si_w5");
        wr_chk(16'h0006, 18'h10006, 16'd5, "si_w6");
        idle_chk(1'b1, 16'd6, "si_done");
        idle_chk(1'b0, 16'd6, "si_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifmap_row_loader.md
Name: ifmap_row_loader

Overview:
- Upstream feeder for the PE datapath's IFMap FIFO. Accepts a valid/ready pixel stream from the activation memory and tags each pixel with start-of-row and end-of-row flags.
- Writes the tagged IFMap words into the IFMap FIFO, never writing while the FIFO is full.
- Counts columns and rows of a programmed frame and pulses done after the last pixel is written.

Parameters:
- DATA_WIDTH, 16, pixel payload width.
- IFMAP_WIDTH, 18, FIFO word width. Equals DATA_WIDTH+2.
- LEN_SIZE, 8, width of the row-length and row-count registers and counters.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse that latches row_len/num_rows and begins a frame. Honoured only in IDLE.
- row_len  input  LEN_SIZE  pixels per row.
- num_rows  input  LEN_SIZE  rows per frame.
- in_data  input  DATA_WIDTH  pixel from activation memory.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- fifo_full  input  1  IFMap FIFO full flag.
- fifo_wen  output  1  IFMap FIFO write enable.
- fifo_din  output  IFMAP_WIDTH  tagged word: [17]=start_of_row, [16]=end_of_row, [15:0]=pixel.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse when the frame completes.
- pix_count  output  2*LEN_SIZE  pixels written in the current or last frame.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - State returns to IDLE; col_cnt, row_cnt and pix_count clear to 0; the latched length registers clear to 0.
  - Outputs in_ready, fifo_wen, fifo_din, busy and done are all 0.
  - Reset mid-frame aborts the frame: no done pulse and no further writes.
- State IDLE:
  - start=1 latches row_len→len_r and num_rows→rows_r, and clears col_cnt, row_cnt and pix_count.
  - If either latched value is 0, go to DONE with zero writes. Otherwise go to LOAD.
  - start is ignored outside IDLE.
- State LOAD:
  - in_ready = !fifo_full, combinational.
  - A transfer happens when in_valid && in_ready. In that cycle, fifo_wen=1 and fifo_din = {col_cnt==0, col_cnt==len_r-1, in_data}, both combinational, so pixel-to-FIFO latency is zero cycles.
  - On each transfer, pix_count increments by 1.
  - When col_cnt==len_r-1: col_cnt←0 and row_cnt←row_cnt+1. Otherwise col_cnt←col_cnt+1.
  - When the transfer has col_cnt==len_r-1 and row_cnt==rows_r-1, go to DONE.
  - With len_r==1, the single word carries both flags (bits 17 and 16 = 1).
- State DONE:
  - done=1 for exactly one cycle, then return to IDLE. in_ready=0.
  - pix_count holds its value until the next start.
- Backpressure and idle input:
  - fifo_full=1 forces in_ready=0 and fifo_wen=0. Counters hold and the pending pixel stays on the input interface.
  - in_valid=0 leaves the counters unchanged and holds fifo_wen=0.
- fifo_wen is never asserted while fifo_full=1, and never outside LOAD.
- Width rules:
  - Counter compares use LEN_SIZE-bit unsigned values, so row_len=255 is legal.
  - pix_count is 2*LEN_SIZE bits, so the maximum 255×255 frame does not wrap.
- busy = (state==LOAD).

Test Plan:
- Basic frame: reset, start with row_len=3, num_rows=2, in_valid held 1, fifo_full=0, pixels 0x0001..0x0006 → six consecutive fifo_wen cycles.
  - fifo_din sequence: 0x20001, 0x00002, 0x10003, 0x20004, 0x00005, 0x10006.
  - done pulses one cycle after the last write; pix_count=6; busy drops.
- Backpressure: same frame with fifo_full=1 for 4 cycles after the 2nd write → in_ready=0 and fifo_wen=0 during the stall.
  - The 3rd word 0x10003 is written on the first cycle after fifo_full falls; no word is lost or duplicated.
- Sparse input: row_len=4, num_rows=1, in_valid toggling 1,0,1,0,… → exactly 4 writes (flags 10,00,00,01 in bits [17:16]), then done; pix_count=4.
- Degenerate sizes:
  - row_len=1, num_rows=3 → three words, each with bits [17:16]=11, then done.
  - row_len=0 → done after start with zero fifo_wen; pix_count=0.
- Mid-frame reset and restart: rstn=0 after 2 writes of a 3×2 frame → outputs 0, state IDLE, no done.
  - A new start with row_len=2, num_rows=1 then produces 0x2xxxx, 0x1xxxx and done.
- Start ignored while busy: pulse start with row_len=5 during the 3×2 frame → the frame still ends after 6 words; pix_count=6.
